// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM state encoding and
// the helper that turns a clock rate and a microsecond budget into cycles.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int unsigned DEF_CLK_HZ     = 25000000;
    localparam int unsigned DEF_TIMEOUT_US = 2000;

    // Cycles in the inter-edge timeout window.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned us);
        return (clk_hz / 1000000) * us;
    endfunction

    localparam int unsigned TIMEOUT = timeout_cycles(DEF_CLK_HZ, DEF_TIMEOUT_US);

endpackage

// File: rtl/ps2_fifo.sv
// Small first-word-fall-through FIFO for received scancodes. Pointers carry
// one extra wrap bit so full and empty are told apart without a counter.
// A push into a full FIFO is dropped and latched in the sticky overflow flag.
module ps2_fifo #(
    parameter int LOG2  = 3,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             overflow
);

    localparam int DEPTH = 1 << LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2:0]    wr_ptr_reg;
    logic [LOG2:0]    rd_ptr_reg;
    logic             overflow_reg;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[LOG2] != rd_ptr_reg[LOG2]) &&
                   (wr_ptr_reg[LOG2-1:0] == rd_ptr_reg[LOG2-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands when the head is being consumed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Head is shown combinationally; forced to zero while empty so the
    // output is clean straight out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr_reg[LOG2-1:0]];
    assign overflow = overflow_reg;

    // Storage array, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg[LOG2-1:0]] <= push_data;
        end
    end

    // Pointer and sticky overflow update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (do_pop) begin
                overflow_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises and de-glitches the keyboard lines,
// deserialises 11-bit frames on filtered falling clock edges, validates
// start/parity/stop and queues good scancodes for the core.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int          FILTER     = 8,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int          FIFO_LOG2  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       err
);

    localparam int unsigned TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int          CNT_W       = $clog2(TIMEOUT_CYC);
    localparam int          FILT_W      = $clog2(FILTER + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER - 1);

    logic              clk_meta_reg;
    logic              clk_sync_reg;
    logic              dat_meta_reg;
    logic              dat_sync_reg;
    logic              clk_filt_reg;
    logic [FILT_W-1:0] filt_cnt_reg;
    rx_state_t         state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic              parity_reg;
    logic              err_reg;
    logic [CNT_W-1:0]  tmo_reg;
    logic              fall_edge;
    logic              frame_ok;
    logic              push;
    logic              fifo_empty;

    // The filtered level is about to drop from 1 to 0 this cycle.
    assign fall_edge = clk_filt_reg && !clk_sync_reg && (filt_cnt_reg == FILT_LAST);
    // Stop bit high and odd parity over data plus parity bit.
    assign frame_ok  = dat_sync_reg && ((^shift_reg) ^ parity_reg);
    assign push      = fall_edge && (state_reg == STOP) && frame_ok;

    // Two-flop synchronisers on both raw lines; idle level is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta_reg <= 1'b1;
            clk_sync_reg <= 1'b1;
            dat_meta_reg <= 1'b1;
            dat_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg <= ps2_clk;
            clk_sync_reg <= clk_meta_reg;
            dat_meta_reg <= ps2_dat;
            dat_sync_reg <= dat_meta_reg;
        end
    end

    // Clock de-glitch: follow the synchronised level only after FILTER
    // consecutive samples disagree with the current filtered level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_filt_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (clk_sync_reg == clk_filt_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == FILT_LAST) begin
            clk_filt_reg <= clk_sync_reg;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    // Frame FSM with inter-edge timeout; err is a registered one-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            err_reg     <= 1'b0;
            tmo_reg     <= '0;
        end else begin
            err_reg <= 1'b0;
            if (state_reg == IDLE || fall_edge) begin
                tmo_reg <= '0;
            end else begin
                tmo_reg <= tmo_reg + 1'b1;
            end

            if (fall_edge) begin
                case (state_reg)
                    IDLE: begin
                        if (!dat_sync_reg) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {dat_sync_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_reg <= dat_sync_reg;
                        state_reg  <= STOP;
                    end
                    default: begin
                        if (!frame_ok) begin
                            err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                endcase
            end else if (state_reg != IDLE && tmo_reg == TMO_LAST) begin
                state_reg <= IDLE;
                err_reg   <= 1'b1;
                tmo_reg   <= '0;
            end
        end
    end

    ps2_fifo #(
        .LOG2  (FIFO_LOG2),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rd),
        .pop_data  (data),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign ready = !fifo_empty;
    assign err   = err_reg;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard. Frames are bit-banged on ps2_clk/ps2_dat;
// each good frame pushes its expected scancode into a model queue, and a
// monitor pops and compares whenever the bench reads a byte from the DUT.
// Scaled clock (1 MHz, 200 us timeout) keeps frame timing proportionate.
module tb_ps2_keyboard;

    localparam int HALF = 24;
    localparam int TMO  = 200;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       rd;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_q[$];

    ps2_keyboard #(
        .CLK_HZ     (1000000),
        .FILTER     (8),
        .TIMEOUT_US (TMO),
        .FIFO_LOG2  (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rd       (rd),
        .data     (data),
        .ready    (ready),
        .overflow (overflow),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Monitor: every accepted read is compared against the model head.
    always @(negedge clock) begin
        if (err === 1'b1) begin
            err_seen++;
        end
        if (rd === 1'b1 && ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0h expected=none", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                exp_ovf = 1'b0;
                if (data !== e) begin
                    errors++;
                    $display("FAIL pop_data actual=%0h expected=%0h", data, e);
                end else begin
                    $display("pop  data=%0h", data);
                end
            end
        end
    end

    // Model side of a good frame: stored if room, otherwise flagged dropped.
    task automatic expect_push(input logic [7:0] b);
        if (exp_q.size() < 8) begin
            exp_q.push_back(b);
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    // mode 1: check ready latency around the stop edge; mode 2: pulse rd in
    // the cycle the stop bit is taken so pop and push coincide.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                              input int mode, input logic glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clock); #1 ps2_dat = fr[i];
            for (int c = 0; c < HALF; c++) begin
                @(posedge clock); #1 ps2_clk = (glitch && c >= 12 && c < 15) ? 1'b0 : 1'b1;
            end
            @(posedge clock); #1 ps2_clk = 1'b0;
            for (int c = 1; c < HALF; c++) begin
                @(posedge clock); #1 ps2_clk = (glitch && c >= 14 && c < 17) ? 1'b1 : 1'b0;
                if (i == 10 && mode == 1 && c == 9) check("ready_before_push", 32'(ready), 32'd0);
                if (i == 10 && mode == 1 && c == 10) check("ready_after_push", 32'(ready), 32'd1);
                if (i == 10 && mode == 2 && c == 9) rd = 1'b1;
                if (i == 10 && mode == 2 && c == 10) rd = 1'b0;
            end
        end
        @(posedge clock); #1 ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (40) @(posedge clock);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clock); #1 rd = 1'b1;
        @(posedge clock); #1 rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Basic frame, push latency and pop back to empty.
        send_frame(8'h1C, 1'b0, 11, 1, 1'b0);
        expect_push(8'h1C);
        pop_one();
        check("empty_after_pop", 32'(ready), 32'd0);

        // Bad parity: one err pulse, nothing queued.
        send_frame(8'hF0, 1'b1, 11, 0, 1'b0);
        err_exp++;
        check("parity_err_count", 32'(err_seen), 32'(err_exp));
        check("parity_no_ready", 32'(ready), 32'd0);

        // Truncated frame times out, next frame is clean.
        send_frame(8'h00, 1'b0, 4, 0, 1'b0);
        repeat (TMO + 50) @(posedge clock);
        #1;
        err_exp++;
        check("timeout_err_count", 32'(err_seen), 32'(err_exp));
        send_frame(8'h5A, 1'b0, 11, 0, 1'b0);
        expect_push(8'h5A);
        check("after_timeout_ready", 32'(ready), 32'd1);
        pop_one();

        // Nine frames into an eight-deep FIFO.
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0, 11, 0, 1'b0);
            expect_push(8'(k));
        end
        check("overflow_set", 32'(overflow), 32'(exp_ovf));
        pop_one();
        check("overflow_cleared", 32'(overflow), 32'(exp_ovf));
        repeat (7) pop_one();
        check("drained_ready", 32'(ready), 32'd0);

        // Glitches on ps2_clk shorter than the filter window.
        send_frame(8'h29, 1'b0, 11, 0, 1'b1);
        expect_push(8'h29);
        pop_one();
        check("glitch_err_count", 32'(err_seen), 32'(err_exp));

        // Full FIFO with a pop coinciding with the push of 0x77.
        for (int k = 0; k < 8; k++) begin
            send_frame(8'h10 + 8'(k), 1'b0, 11, 0, 1'b0);
            expect_push(8'h10 + 8'(k));
        end
        send_frame(8'h77, 1'b0, 11, 2, 1'b0);
        expect_push(8'h77);
        check("simul_no_overflow", 32'(overflow), 32'(exp_ovf));
        repeat (8) pop_one();
        check("simul_count_eight", 32'(ready), 32'd0);

        // Reset with queued data and a partial frame: all discarded, no err.
        send_frame(8'h33, 1'b0, 11, 0, 1'b0);
        send_frame(8'h00, 1'b0, 5, 0, 1'b0);
        @(posedge clock); #1 reset = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_mid_ready", 32'(ready), 32'd0);
        repeat (TMO + 50) @(posedge clock);
        #1;
        check("reset_mid_no_err", 32'(err_seen), 32'(err_exp));
        check("model_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
